rf_master_seq: RTL and testbench
================================

Name: rf_master_seq

Overview:
- Instruction-driven initiator for the 8x8 register file (two read ports, one write port, rw select: 0 read, 1 write).
- Accepts 16-bit micro-instructions over a valid/ready handshake, then sequences the register file through a read phase, an ALU execute phase and a write-back phase.
- Reports each result, carry and completion upstream.
- Sits between the instruction source (testbench or future fetch unit) and the register file.

Parameters:
- DW, 8, register data width; must match the register file.
- AW, 3, register address width (8 registers).
- CNTW, 16, width of the retired-instruction counter.

Ports:
- i_clk  in  1  system clock; all state changes on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_instr  in  16  instruction word.
- i_valid  in  1  instruction valid.
- o_ready  out  1  controller can accept an instruction.
- o_rf_addr1  out  AW  register file read address, port 1.
- o_rf_addr2  out  AW  register file read address, port 2.
- o_rf_addrwr  out  AW  register file write address.
- o_rf_rw  out  1  register file mode (0 read, 1 write).
- o_rf_dataIn  out  DW  register file write data.
- i_rf_data1  in  DW  register file read data, port 1.
- i_rf_data2  in  DW  register file read data, port 2.
- o_result  out  DW  last written value.
- o_carry  out  1  carry/borrow of last ADD/SUB.
- o_done  out  1  one-cycle pulse when write-back completes.
- o_count  out  CNTW  retired-instruction counter.

Behaviour:
- Instruction fields:
  - [15:13] opcode; [12:10] rd; [9:7] rs1; [6:4] rs2; [7:0] imm8 (LDI only).
  - Unused bits are ignored.
- Opcodes:
  - 000 NOP.
  - 001 ADD: rd = rs1 + rs2.
  - 010 SUB: rd = rs1 - rs2.
  - 011 AND, 100 OR, 101 XOR.
  - 110 LDI: rd = imm8.
  - 111 MOV: rd = rs1.
- Arithmetic:
  - ADD/SUB use DW+1-bit math; the result is truncated to DW.
  - ADD: o_carry = bit DW of the sum.
  - SUB: o_carry = 1 when rs1 < rs2 (unsigned borrow).
  - All other opcodes leave o_carry unchanged.
- FSM states:
  - IDLE: o_ready=1. On i_valid, latch i_instr. NOP goes to DONE; LDI goes to WRITE; all others go to READ.
  - READ: 1 cycle. o_rf_rw=0, o_rf_addr1=rs1, o_rf_addr2=rs2. Next state EXEC.
  - EXEC: 1 cycle. Addresses held and o_rf_rw=0. Sample i_rf_data1/2, compute the result into an internal register. Next state WRITE.
  - WRITE: 1 cycle. o_rf_rw=1, o_rf_addrwr=rd, o_rf_dataIn=result. Next state DONE.
  - DONE: 1 cycle. o_done=1; o_result updated (NOP leaves it unchanged); o_count increments. Next state IDLE.
- Handshake and latency:
  - o_ready is asserted only in IDLE; the transfer occurs on a cycle with i_valid & o_ready.
  - i_instr is don't-care outside transfer cycles.
  - i_valid is ignored while busy; no queueing.
  - From the accept edge to o_done high: ALU/MOV = 4 cycles, LDI = 2, NOP = 1.
  - Next accept is possible on the cycle after DONE (i.e. one IDLE cycle minimum between instructions).
- Register file outputs:
  - o_rf_rw is 0 in every state except WRITE, so exactly one write pulse per non-NOP instruction.
  - o_rf_addrwr and o_rf_dataIn hold their last values outside WRITE.
- Boundaries:
  - rd may equal rs1/rs2: operands are sampled in EXEC, before WRITE, so the old values are used.
  - rs1 == rs2 is legal.
  - o_count wraps from 2^CNTW-1 to 0.
- Reset, applied in any state, including mid-instruction:
  - Next state IDLE; o_ready=1 after the reset edge.
  - o_rf_rw=0; all addresses 0; o_rf_dataIn=0.
  - o_result=0, o_carry=0, o_done=0, o_count=0.
  - Any in-flight instruction is abandoned with no write pulse.

Test Plan:
- Reset, then LDI r1=0x7F and LDI r2=0x01 -> one o_rf_rw pulse each with addrwr 1/2 and dataIn 0x7F/0x01; o_done 2 cycles after each accept; o_count=2.
- With r1=0xFF, r2=0x01, ADD r3=r1+r2 -> READ drives addr1=1, addr2=2 with rw=0; WRITE drives addrwr=3, dataIn=0x00; o_carry=1; o_result=0x00; latency 4.
- With r4=0x05, r5=0x09, SUB r4=r4-r5 (rd==rs1) -> write 0xFC to r4; o_carry=1. Then AND/OR/XOR of 0xF0 and 0x3C -> 0x30, 0xFC, 0xCC respectively; o_carry unchanged.
- Hold i_valid high continuously with 3 queued instructions -> o_ready low during READ..DONE; instructions accepted only in IDLE; none dropped or duplicated; o_count=3.
- Assert i_rst during EXEC of an ADD -> no o_rf_rw pulse ever occurs; all outputs read their reset values the next cycle; a new instruction is accepted the cycle after reset deasserts.
- Preload o_count to 0xFFFF via 65535 NOPs, then issue one more NOP -> o_count wraps to 0x0000; no o_rf_rw pulse for any NOP.

Source files
------------

// File: rtl/rf_master_seq.sv
// rtl/rf_master_seq.sv - micro-instruction sequencer driving an 8x8 register file through read/execute/write-back
module rf_master_seq #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int CNTW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [15:0]     i_instr,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [AW-1:0]   o_rf_addr1,
    output logic [AW-1:0]   o_rf_addr2,
    output logic [AW-1:0]   o_rf_addrwr,
    output logic            o_rf_rw,
    output logic [DW-1:0]   o_rf_dataIn,
    input  logic [DW-1:0]   i_rf_data1,
    input  logic [DW-1:0]   i_rf_data2,
    output logic [DW-1:0]   o_result,
    output logic            o_carry,
    output logic            o_done,
    output logic [CNTW-1:0] o_count
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      op_q;
    logic [AW-1:0]   rd_q;
    logic            alu_c_q;
    logic [DW-1:0]   alu_res;
    logic            alu_c;
    logic [DW:0]     sum;
    logic [DW:0]     diff;

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_rf_rw   = 1'b0;
        o_done    = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    if (i_instr[15:13] == OP_NOP)
                        state_nxt = S_DONE;
                    else if (i_instr[15:13] == OP_LDI)
                        state_nxt = S_WRITE;
                    else
                        state_nxt = S_READ;
                end
            end
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WRITE;
            S_WRITE: begin
                o_rf_rw   = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Borrow of the unsigned subtract lands in bit DW, same as the add carry.
    always_comb begin
        sum     = {1'b0, i_rf_data1} + {1'b0, i_rf_data2};
        diff    = {1'b0, i_rf_data1} - {1'b0, i_rf_data2};
        alu_res = i_rf_data1;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[DW-1:0];
                alu_c   = sum[DW];
            end
            OP_SUB: begin
                alu_res = diff[DW-1:0];
                alu_c   = diff[DW];
            end
            OP_AND:  alu_res = i_rf_data1 & i_rf_data2;
            OP_OR:   alu_res = i_rf_data1 | i_rf_data2;
            OP_XOR:  alu_res = i_rf_data1 ^ i_rf_data2;
            OP_MOV:  alu_res = i_rf_data1;
            default: alu_res = i_rf_data1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            op_q        <= OP_NOP;
            rd_q        <= '0;
            alu_c_q     <= 1'b0;
            o_rf_addr1  <= '0;
            o_rf_addr2  <= '0;
            o_rf_addrwr <= '0;
            o_rf_dataIn <= '0;
            o_result    <= '0;
            o_carry     <= 1'b0;
            o_count     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        op_q <= i_instr[15:13];
                        rd_q <= AW'(i_instr[12:10]);
                        if (i_instr[15:13] == OP_LDI) begin
                            o_rf_addrwr <= AW'(i_instr[12:10]);
                            o_rf_dataIn <= DW'(i_instr[7:0]);
                        end else if (i_instr[15:13] != OP_NOP) begin
                            o_rf_addr1 <= AW'(i_instr[9:7]);
                            o_rf_addr2 <= AW'(i_instr[6:4]);
                        end
                    end
                end
                S_EXEC: begin
                    o_rf_addrwr <= rd_q;
                    o_rf_dataIn <= alu_res;
                    alu_c_q     <= alu_c;
                end
                // Result and carry become visible together with the done pulse.
                S_WRITE: begin
                    o_result <= o_rf_dataIn;
                    if (op_q == OP_ADD || op_q == OP_SUB)
                        o_carry <= alu_c_q;
                end
                default: ;
            endcase
            if (state_nxt == S_DONE)
                o_count <= o_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_rf_master_seq.sv
// tb/tb_rf_master_seq.sv - randomized self-checking bench for rf_master_seq against a latency/arithmetic model
module tb_rf_master_seq;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [15:0]     instr;
    logic            valid;
    logic            ready;
    logic [AW-1:0]   addr1, addr2, addrwr;
    logic            rf_rw;
    logic [DW-1:0]   data_in, rf_d1, rf_d2, result;
    logic            carry, done;
    logic [CNTW-1:0] count;

    always #5 clk = ~clk;

    rf_master_seq #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_valid(valid), .o_ready(ready),
        .o_rf_addr1(addr1), .o_rf_addr2(addr2), .o_rf_addrwr(addrwr), .o_rf_rw(rf_rw),
        .o_rf_dataIn(data_in), .i_rf_data1(rf_d1), .i_rf_data2(rf_d2),
        .o_result(result), .o_carry(carry), .o_done(done), .o_count(count)
    );

    // Register file seen by the DUT
    logic [7:0] rf_mem [8] = '{default: 8'h00};
    int n_wr = 0;
    assign rf_d1 = rf_mem[addr1];
    assign rf_d2 = rf_mem[addr2];
    always @(posedge clk) begin
        if (rf_rw) begin
            rf_mem[addrwr] <= data_in;
            n_wr <= n_wr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: golden register file plus one pending instruction
    logic [7:0]      gold [8] = '{default: 8'h00};
    bit              pend = 0;
    int              acc_edge = 0;
    int              lat = 0;
    int              n_accept = 0;
    logic [2:0]      m_op = 0, m_rd = 0, m_rs1 = 0, m_rs2 = 0;
    logic [7:0]      m_val = 0;
    bit              m_cnew = 0;
    logic [7:0]      m_result = 0;
    bit              m_carry = 0;
    logic [CNTW-1:0] m_count = 0;
    logic [2:0]      m_wa = 0;
    logic [7:0]      m_wd = 0;
    bit              after_rst = 1;

    task automatic model_accept(input logic [15:0] w);
        logic [7:0] a, b;
        logic [8:0] s;
        m_op  = w[15:13];
        m_rd  = w[12:10];
        m_rs1 = w[9:7];
        m_rs2 = w[6:4];
        a = gold[m_rs1];
        b = gold[m_rs2];
        m_cnew = 0;
        m_val  = 0;
        lat    = 4;
        case (m_op)
            3'd0: lat = 1;
            3'd1: begin s = a + b; m_val = s[7:0]; m_cnew = s[8]; end
            3'd2: begin m_val = a - b; m_cnew = (a < b); end
            3'd3: m_val = a & b;
            3'd4: m_val = a | b;
            3'd5: m_val = a ^ b;
            3'd6: begin m_val = w[7:0]; lat = 2; end
            default: m_val = a;
        endcase
        pend = 1;
        acc_edge = cyc;
        n_accept++;
    endtask

    always @(negedge clk) begin
        int d;
        bit e_ready, e_rw, e_done;
        d       = cyc - acc_edge;
        e_ready = !pend;
        e_rw    = pend && m_op != 3'd0 && d == lat - 1;
        e_done  = pend && d == lat;
        if (e_rw) begin
            m_wa = m_rd;
            m_wd = m_val;
            gold[m_rd] = m_val;
        end
        if (e_done) begin
            m_count = m_count + 1'b1;
            if (m_op != 3'd0) m_result = m_val;
            if (m_op == 3'd1 || m_op == 3'd2) m_carry = m_cnew;
        end
        chk("ready", ready, e_ready);
        chk("rf_rw", rf_rw, e_rw);
        chk("done", done, e_done);
        chk("addrwr", addrwr, m_wa);
        chk("dataIn", data_in, m_wd);
        chk("result", result, m_result);
        chk("carry", carry, m_carry);
        chk("count", count, m_count);
        if (pend && m_op != 3'd0 && m_op != 3'd6 && (d == 1 || d == 2)) begin
            chk("addr1", addr1, m_rs1);
            chk("addr2", addr2, m_rs2);
        end
        if (after_rst) begin
            chk("addr1_rst", addr1, 0);
            chk("addr2_rst", addr2, 0);
            after_rst = 0;
        end
        if (e_done) pend = 0;
        if (rst) begin
            pend = 0; m_result = 0; m_carry = 0; m_count = 0;
            m_wa = 0; m_wd = 0; after_rst = 1;
        end else if (valid && e_ready) begin
            model_accept(instr);
        end
    end

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return {op[2:0], rd[2:0], rs1[2:0], rs2[2:0], 4'h0};
    endfunction

    function automatic logic [15:0] ldi(input int rd, input logic [7:0] imm);
        return {3'b110, rd[2:0], 2'b00, imm};
    endfunction

    task automatic send(input logic [15:0] w, input bit keep);
        int n = 0;
        valid = 1;
        instr = w;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 20);
        if (!ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        valid = keep;
        instr = $urandom;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, acc0;
        logic [15:0] w;
        bit keep;
        rst = 1; valid = 0; instr = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // LDI pair
        w0 = n_wr;
        send(ldi(1, 8'h7F), 0);
        send(ldi(2, 8'h01), 0);
        settle();
        chk("ldi_r1", rf_mem[1], 8'h7F);
        chk("ldi_r2", rf_mem[2], 8'h01);
        chk("ldi_pulses", n_wr - w0, 2);
        chk("ldi_count", count, 2);

        // ADD with carry out
        send(ldi(1, 8'hFF), 0);
        send(enc(1, 3, 1, 2), 0);
        settle();
        chk("add_r3", rf_mem[3], 8'h00);
        chk("add_result", result, 8'h00);
        chk("add_carry", carry, 1);

        // SUB with rd == rs1, then logic ops leave carry alone
        send(ldi(4, 8'h05), 0);
        send(ldi(5, 8'h09), 0);
        send(enc(2, 4, 4, 5), 0);
        settle();
        chk("sub_r4", rf_mem[4], 8'hFC);
        chk("sub_carry", carry, 1);
        send(ldi(6, 8'hF0), 0);
        send(ldi(7, 8'h3C), 0);
        send(enc(3, 0, 6, 7), 0);
        settle();
        chk("and_result", result, 8'h30);
        send(enc(4, 0, 6, 7), 0);
        settle();
        chk("or_result", result, 8'hFC);
        send(enc(5, 0, 6, 7), 0);
        settle();
        chk("xor_result", result, 8'hCC);
        chk("logic_carry", carry, 1);

        // Valid held high across three back-to-back instructions
        reset_pulse();
        acc0 = n_accept;
        send(enc(7, 2, 6, 0), 1);
        send(enc(1, 5, 2, 7), 1);
        send(enc(5, 1, 5, 5), 0);
        settle();
        chk("queue_accepts", n_accept - acc0, 3);
        chk("queue_count", count, 3);

        // Reset during EXEC of an ADD abandons it
        w0 = n_wr;
        send(enc(1, 6, 1, 2), 0);
        @(posedge clk);
        #1;
        reset_pulse();
        acc0 = n_accept;
        send(ldi(0, 8'hA5), 0);
        settle();
        chk("rst_accept", n_accept - acc0, 1);
        chk("rst_pulses", n_wr - w0, 1);
        chk("rst_r6_kept", rf_mem[6], 8'hF0);
        chk("rst_count", count, 1);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++) begin
            w = $urandom;
            keep = ($urandom_range(0, 3) == 0);
            send(w, keep);
            if (!keep) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        valid = 0;
        settle();
        for (int r = 0; r < 8; r++) chk("rf_final", rf_mem[r], gold[r]);

        // Counter wrap with NOPs
        reset_pulse();
        w0 = n_wr;
        for (int i = 0; i < (1 << CNTW) - 1; i++) begin
            w = $urandom;
            w[15:13] = 3'b000;
            send(w, 1);
        end
        valid = 0;
        settle();
        chk("wrap_full", count, (1 << CNTW) - 1);
        send(16'h1FFF, 0);
        settle();
        chk("wrap_zero", count, 0);
        chk("nop_pulses", n_wr - w0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
